// File: rtl/rom_load_sched.sv
`default_nettype none
// ============================================================================
// rom_load_sched: buffers HPS download bytes and replays them as paced,
// region-tagged ROM writes while sequencing the core reset.
// Optional: define ROM_LOAD_SCHED_CKSUM_EN to build the cksum accumulator.
// Revision: 1.0
// ============================================================================
module rom_load_sched #(
  parameter int                ADDR_W     = 17,
  parameter logic [ADDR_W-1:0] RGN1_BASE  = 17'h04000,
  parameter logic [ADDR_W-1:0] RGN2_BASE  = 17'h0C000,
  parameter logic [ADDR_W-1:0] RGN3_BASE  = 17'h14000,
  parameter logic [ADDR_W-1:0] ROM_END    = 17'h1C000,
  parameter int                FIFO_DEPTH = 4,
  parameter int                WR_GAP     = 2,
  parameter int                POST_HOLD  = 256
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr,
  output logic [3:0]        dn_rgn,
  output logic              core_reset,
  output logic              rom_ready,
  output logic              err_ovf,
  output logic              err_range,
  output logic [ADDR_W:0]   byte_cnt,
  output logic [15:0]       cksum
);

  localparam int c_ptr_w  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_w  = $clog2(FIFO_DEPTH + 1);
  localparam int c_gap_w  = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
  localparam int c_hold_w = $clog2(POST_HOLD + 1);

  localparam logic [c_cnt_w-1:0]  c_full      = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_gap_w-1:0]  c_gap_load  = c_gap_w'(WR_GAP - 1);
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(POST_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_HOLD  = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_clear;

  logic                r_dl_prev;
  logic [ADDR_W-1:0]   r_mem_addr [FIFO_DEPTH];
  logic [7:0]          r_mem_data [FIFO_DEPTH];
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_cnt_w-1:0]  r_count;
  logic [c_gap_w-1:0]  r_gap;
  logic [c_hold_w-1:0] r_hold_cnt;

  logic [ADDR_W-1:0]   r_dn_addr;
  logic [7:0]          r_dn_data;
  logic                r_dn_wr;
  logic [3:0]          r_dn_rgn;
  logic                r_core_reset;
  logic                r_rom_ready;
  logic                r_err_ovf;
  logic                r_err_range;
  logic [ADDR_W:0]     r_byte_cnt;

  logic                w_rise;
  logic                w_empty;
  logic                w_full;
  logic                w_gap_zero;
  logic                w_strobe;
  logic                w_in_range;
  logic                w_pop;
  logic                w_push;
  logic                w_ovf;
  logic                w_range_err;
  logic [ADDR_W-1:0]   w_head_addr;
  logic [7:0]          w_head_data;

  function automatic logic [3:0] f_region(input logic [ADDR_W-1:0] a);
    if (a < RGN1_BASE) return 4'b0001;
    if (a < RGN2_BASE) return 4'b0010;
    if (a < RGN3_BASE) return 4'b0100;
    return 4'b1000;
  endfunction

  assign w_rise      = ioctl_download & ~r_dl_prev;
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == c_full);
  assign w_gap_zero  = (r_gap == '0);
  assign w_strobe    = ioctl_wr && (r_state == S_LOAD);
  assign w_in_range  = (ioctl_addr < ROM_END);
  assign w_pop       = !w_empty && w_gap_zero;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign w_push      = w_strobe && w_in_range && (!w_full || w_pop);
  assign w_ovf       = w_strobe && w_in_range && w_full && !w_pop;
  assign w_range_err = w_strobe && !w_in_range;
  assign w_head_addr = r_mem_addr[r_rd_ptr];
  assign w_head_data = r_mem_data[r_rd_ptr];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Re-entry from DRAIN continues the same download, so only fresh loads clear.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE, S_RUN: begin
        if (w_rise) begin
          w_state_nxt = S_LOAD;
          w_clear     = 1'b1;
        end
      end
      S_LOAD: begin
        if (!ioctl_download) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_rise)                       w_state_nxt = S_LOAD;
        else if (w_empty && w_gap_zero)   w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (w_rise) begin
          w_state_nxt = S_LOAD;
          w_clear     = 1'b1;
        end else if (r_hold_cnt == c_hold_last) begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= ioctl_addr;
      r_mem_data[r_wr_ptr] <= ioctl_dout;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_dl_prev    <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_gap        <= '0;
      r_hold_cnt   <= '0;
      r_dn_addr    <= '0;
      r_dn_data    <= '0;
      r_dn_wr      <= 1'b0;
      r_dn_rgn     <= 4'b0000;
      r_core_reset <= 1'b1;
      r_rom_ready  <= 1'b0;
      r_err_ovf    <= 1'b0;
      r_err_range  <= 1'b0;
      r_byte_cnt   <= '0;
    end else begin
      r_dl_prev    <= ioctl_download;
      r_core_reset <= (w_state_nxt != S_RUN);
      r_rom_ready  <= (w_state_nxt == S_RUN);

      if (r_state == S_HOLD) r_hold_cnt <= r_hold_cnt + c_hold_w'(1);
      else                   r_hold_cnt <= '0;

      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase

      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + c_ptr_w'(1);
        r_dn_addr <= w_head_addr;
        r_dn_data <= w_head_data;
        r_dn_wr   <= 1'b1;
        r_dn_rgn  <= f_region(w_head_addr);
        r_gap     <= c_gap_load;
      end else begin
        r_dn_wr   <= 1'b0;
        r_dn_rgn  <= 4'b0000;
        if (!w_gap_zero) r_gap <= r_gap - c_gap_w'(1);
      end

      if (w_clear) begin
        r_err_ovf   <= 1'b0;
        r_err_range <= 1'b0;
        r_byte_cnt  <= '0;
      end else begin
        if (w_ovf)       r_err_ovf   <= 1'b1;
        if (w_range_err) r_err_range <= 1'b1;
        if (w_push)      r_byte_cnt  <= r_byte_cnt + (ADDR_W + 1)'(1);
      end
    end
  end

`ifdef ROM_LOAD_SCHED_CKSUM_EN
  logic [15:0] r_cksum;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_cksum <= 16'h0000;
    end else if (w_clear) begin
      r_cksum <= 16'h0000;
    end else if (w_push) begin
      r_cksum <= r_cksum + {8'h00, ioctl_dout};
    end
  end

  assign cksum = r_cksum;
`else
  assign cksum = 16'h0000;
`endif

  assign dn_addr    = r_dn_addr;
  assign dn_data    = r_dn_data;
  assign dn_wr      = r_dn_wr;
  assign dn_rgn     = r_dn_rgn;
  assign core_reset = r_core_reset;
  assign rom_ready  = r_rom_ready;
  assign err_ovf    = r_err_ovf;
  assign err_range  = r_err_range;
  assign byte_cnt   = r_byte_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rom_load_sched.sv
`default_nettype none
// tb_rom_load_sched: directed and random download traffic checked every cycle
// against a queue-based model of the download scheduler.
module tb_rom_load_sched;

  localparam int          ADDR_W     = 17;
  localparam int          FIFO_DEPTH = 4;
  localparam int          WR_GAP     = 2;
  localparam int          POST_HOLD  = 256;
  localparam logic [16:0] RGN1       = 17'h04000;
  localparam logic [16:0] RGN2       = 17'h0C000;
  localparam logic [16:0] RGN3       = 17'h14000;
  localparam logic [16:0] ROM_END    = 17'h1C000;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [16:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [3:0]  dn_rgn;
  logic        core_reset;
  logic        rom_ready;
  logic        err_ovf;
  logic        err_range;
  logic [17:0] byte_cnt;
  logic [15:0] cksum;

  always #5 clk_sys = ~clk_sys;

  rom_load_sched #(
    .ADDR_W     (ADDR_W),
    .RGN1_BASE  (RGN1),
    .RGN2_BASE  (RGN2),
    .RGN3_BASE  (RGN3),
    .ROM_END    (ROM_END),
    .FIFO_DEPTH (FIFO_DEPTH),
    .WR_GAP     (WR_GAP),
    .POST_HOLD  (POST_HOLD)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .dn_rgn         (dn_rgn),
    .core_reset     (core_reset),
    .rom_ready      (rom_ready),
    .err_ovf        (err_ovf),
    .err_range      (err_range),
    .byte_cnt       (byte_cnt),
    .cksum          (cksum)
  );

  typedef struct packed {
    logic [16:0] a;
    logic [7:0]  d;
  } ent_t;

  // Model: buffered bytes, pacing gap, and download phase flags.
  ent_t        m_q[$];
  ent_t        m_last;
  int          m_gap;
  int          m_hold;
  int          m_cnt;
  logic [15:0] m_sum;
  bit          m_prev, m_load, m_drain, m_run, m_pop, m_eovf, m_erng;

  int          n_checks = 0;
  int          n_err    = 0;
  int          pulses   = 0;
  logic [3:0]  obs_rgn[$];
  logic [7:0]  obs_data[$];

  logic [16:0] rg_addr [7];
  logic [3:0]  rg_exp  [6];

  function automatic logic [3:0] exp_region(input logic [16:0] a);
    if (a < RGN1) return 4'b0001;
    if (a < RGN2) return 4'b0010;
    if (a < RGN3) return 4'b0100;
    return 4'b1000;
  endfunction

  function automatic logic [15:0] exp_ck(input logic [15:0] s);
`ifdef ROM_LOAD_SCHED_CKSUM_EN
    return s;
`else
    return s & 16'h0000;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_last  = '0;
    m_gap   = 0;
    m_hold  = 0;
    m_cnt   = 0;
    m_sum   = 16'h0000;
    m_prev  = 1'b0;
    m_load  = 1'b0;
    m_drain = 1'b0;
    m_run   = 1'b0;
    m_pop   = 1'b0;
    m_eovf  = 1'b0;
    m_erng  = 1'b0;
  endtask

  task automatic model_edge();
    bit   rise;
    bit   pop;
    int   sz;
    int   gap_pre;
    ent_t e;
    rise    = ioctl_download && !m_prev;
    sz      = m_q.size();
    gap_pre = m_gap;
    pop     = (sz > 0) && (gap_pre == 0);
    m_pop   = pop;
    if (pop) begin
      m_last = m_q.pop_front();
      m_gap  = WR_GAP - 1;
    end else if (m_gap > 0) begin
      m_gap = m_gap - 1;
    end
    if (ioctl_wr && m_load) begin
      if (ioctl_addr >= ROM_END) begin
        m_erng = 1'b1;
      end else if (sz < FIFO_DEPTH || pop) begin
        e.a = ioctl_addr;
        e.d = ioctl_dout;
        m_q.push_back(e);
        m_cnt = m_cnt + 1;
        m_sum = m_sum + {8'h00, ioctl_dout};
      end else begin
        m_eovf = 1'b1;
      end
    end
    if (rise) begin
      if (!m_drain) begin
        m_cnt  = 0;
        m_sum  = 16'h0000;
        m_eovf = 1'b0;
        m_erng = 1'b0;
      end
      m_load  = 1'b1;
      m_drain = 1'b0;
      m_hold  = 0;
      m_run   = 1'b0;
    end else if (m_load && !ioctl_download) begin
      m_load  = 1'b0;
      m_drain = 1'b1;
    end else if (m_drain && sz == 0 && gap_pre == 0) begin
      m_drain = 1'b0;
      m_hold  = POST_HOLD;
    end else if (m_hold > 0) begin
      m_hold = m_hold - 1;
      if (m_hold == 0) m_run = 1'b1;
    end
    m_prev = ioctl_download;
  endtask

  task automatic check_outputs();
    check("dn_wr",      dn_wr,      m_pop);
    check("dn_rgn",     dn_rgn,     m_pop ? exp_region(m_last.a) : 4'b0000);
    check("dn_addr",    dn_addr,    m_last.a);
    check("dn_data",    dn_data,    m_last.d);
    check("core_reset", core_reset, !m_run);
    check("rom_ready",  rom_ready,  m_run);
    check("err_ovf",    err_ovf,    m_eovf);
    check("err_range",  err_range,  m_erng);
    check("byte_cnt",   byte_cnt,   m_cnt);
    check("cksum",      cksum,      exp_ck(m_sum));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_dn_wr"},      dn_wr,      0);
    check({tag, "_dn_rgn"},     dn_rgn,     0);
    check({tag, "_dn_addr"},    dn_addr,    0);
    check({tag, "_dn_data"},    dn_data,    0);
    check({tag, "_core_reset"}, core_reset, 1);
    check({tag, "_rom_ready"},  rom_ready,  0);
    check({tag, "_err_ovf"},    err_ovf,    0);
    check({tag, "_err_range"},  err_range,  0);
    check({tag, "_byte_cnt"},   byte_cnt,   0);
    check({tag, "_cksum"},      cksum,      0);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_sys);
    #1;
    check_outputs();
    if (dn_wr === 1'b1) begin
      pulses++;
      obs_rgn.push_back(dn_rgn);
      obs_data.push_back(dn_data);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic strobe(input logic [16:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    step();
    ioctl_wr   = 1'b0;
  endtask

  task automatic rand_strobe();
    strobe(17'($urandom_range(0, 32'h1BFFF)), 8'($urandom_range(0, 255)));
  endtask

  task automatic wait_run(input string tag, input int budget);
    int n;
    n = 0;
    while (rom_ready !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_released"}, rom_ready, 1);
  endtask

  task automatic async_reset(input string tag);
    #3;
    reset = 1'b1;
    #1;
    check_reset_vals(tag);
    model_reset();
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    int p_load;
    int n;
    rg_addr = '{17'h03FFF, 17'h04000, 17'h0BFFF, 17'h0C000, 17'h13FFF, 17'h14000, 17'h1C000};
    rg_exp  = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000};
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    reset          = 1'b0;
    #2 reset = 1'b1;
    #2;
    check_reset_vals("por");
    model_reset();
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    idle(3);

    // Basic sequential load into region 0, then release.
    ioctl_download = 1'b1;
    step();
    check("t1_core_reset_on_rise", core_reset, 1);
    p0 = pulses;
    obs_rgn.delete();
    obs_data.delete();
    for (int i = 0; i < 8; i++) begin
      strobe(17'(i), 8'(8'h10 + i));
      idle(3);
    end
    ioctl_download = 1'b0;
    wait_run("t1", 600);
    check("t1_pulses",   pulses - p0, 8);
    check("t1_byte_cnt", byte_cnt, 8);
    check("t1_cksum",    cksum, exp_ck(16'h009C));
    for (int i = 0; i < obs_data.size() && i < 8; i++) begin
      check("t1_data_order", obs_data[i], 8'(8'h10 + i));
      check("t1_rgn",        obs_rgn[i],  4'b0001);
    end

    // Reload from RUN clears counters and errors.
    ioctl_download = 1'b1;
    step();
    check("t3_core_reset", core_reset, 1);
    check("t3_rom_ready",  rom_ready,  0);
    check("t3_byte_cnt",   byte_cnt,   0);
    check("t3_cksum",      cksum,      0);
    p_load = pulses;

    // Six back-to-back strobes fit with concurrent pops.
    p0 = pulses;
    for (int i = 0; i < 6; i++) rand_strobe();
    idle(20);
    check("t2_pulses",  pulses - p0, 6);
    check("t2_err_ovf", err_ovf, 0);
    check("t2_byte_cnt", byte_cnt, 6);

    // Twelve back-to-back strobes overrun the FIFO.
    for (int i = 0; i < 12; i++) rand_strobe();
    idle(30);
    check("t4_err_ovf", err_ovf, 1);
    check("t4_byte_cnt_eq_pulses", byte_cnt, pulses - p_load);
    check("t4_byte_cnt", byte_cnt, 16);

    // Region boundaries and the first out-of-range address.
    obs_rgn.delete();
    for (int i = 0; i < 7; i++) begin
      strobe(rg_addr[i], 8'(8'hA0 + i));
      idle(2);
    end
    idle(5);
    check("t5_rgn_count", obs_rgn.size(), 6);
    for (int i = 0; i < obs_rgn.size() && i < 6; i++) check("t5_rgn", obs_rgn[i], rg_exp[i]);
    check("t5_err_range", err_range, 1);

    // Download rise during the post-load hold restarts loading.
    ioctl_download = 1'b0;
    n = 0;
    while (m_hold == 0 && n < 100) begin
      step();
      n++;
    end
    idle(10);
    check("t6_in_hold", core_reset, 1);
    ioctl_download = 1'b1;
    step();
    check("t6_byte_cnt_clr",  byte_cnt,  0);
    check("t6_err_ovf_clr",   err_ovf,   0);
    check("t6_err_range_clr", err_range, 0);
    p0 = pulses;
    strobe(17'h0C123, 8'h5A);
    idle(4);
    check("t6_reload_pulse", pulses - p0, 1);
    check("t6_reload_cnt",   byte_cnt, 1);

    // Reset with three bytes still buffered.
    for (int i = 0; i < 5; i++) rand_strobe();
    async_reset("t7");
    p0 = pulses;
    idle(20);
    check("t7_no_pulse_after_reset", pulses - p0, 0);

    // Random traffic, including out-of-range bytes and download toggles.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 4) ioctl_download = ~ioctl_download;
      ioctl_wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 10) ioctl_addr = 17'($urandom_range(32'h1C000, 32'h1FFFF));
      else                            ioctl_addr = 17'($urandom_range(0, 32'h1BFFF));
      ioctl_dout = 8'($urandom_range(0, 255));
      step();
    end
    ioctl_wr = 1'b0;
    if (ioctl_download === 1'b0) begin
      ioctl_download = 1'b1;
      step();
    end
    ioctl_download = 1'b0;
    wait_run("t8", 700);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
